// File: rtl/image_scan_ctrl_pkg.sv
// Shared constants for the image scan controller: FSM encodings, error codes,
// FIFO geometry and the default watchdog limit.
package plc_image_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_EXEC  = 2'd3;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNDR = 2'b10;
    localparam logic [1:0] ERR_WDT  = 2'b11;

    localparam int FIFO_DEPTH = 16;
    localparam int WD_CYC_DEF = 1024;

    // Clamp the requested load count to the per-scan maximum.
    function automatic logic [4:0] ld_count(input logic [4:0] cnt, input int max_ld);
        return (int'(cnt) > max_ld) ? 5'(max_ld) : cnt;
    endfunction

endpackage

// File: rtl/image_scan_ctrl_if.sv
// CPU read port and external bit-FIFO controls of the image scan controller.
// master = controller side, slave = CPU/FIFO side.
interface image_scan_ctrl_if;

    logic CPU_REQ, CPU_DONE, CPU_DATA, CPU_VALID;
    logic F_EN, F_RD, F_WR, F_DIN, F_CLR;
    logic F_DOUT, F_EMPTY, F_FULL;

    modport master (
        input  CPU_REQ, CPU_DONE, F_DOUT, F_EMPTY, F_FULL,
        output CPU_DATA, CPU_VALID, F_EN, F_RD, F_WR, F_DIN, F_CLR
    );

    modport slave (
        output CPU_REQ, CPU_DONE, F_DOUT, F_EMPTY, F_FULL,
        input  CPU_DATA, CPU_VALID, F_EN, F_RD, F_WR, F_DIN, F_CLR
    );

endinterface

// File: rtl/image_scan_ctrl_wdt.sv
// Scan watchdog: counts cycles while RUN is high and flags EXPIRE on the
// cycle the count reaches WD_CYC-1.
module image_wdt
    import plc_image_pkg::*;
#(
    parameter int WD_CYC = WD_CYC_DEF
) (
    input  logic CLK,
    input  logic CLR_N,
    input  logic CLR_CNT,
    input  logic RUN,
    output logic EXPIRE
);
    localparam int CW = $clog2(WD_CYC) + 1;

    logic [CW-1:0] r_cnt;

    assign EXPIRE = RUN && (r_cnt == CW'(WD_CYC - 1));

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N)
            r_cnt <= '0;
        else if (CLR_CNT)
            r_cnt <= '0;
        else if (RUN && !EXPIRE)
            r_cnt <= r_cnt + CW'(1);
    end

endmodule

// File: rtl/image_scan_ctrl.sv
// Image scan controller: loads up to MAX_LD bits of a parallel image into an
// external bit FIFO, then serves them to the CPU one bit per request.
module image_scan_ctrl
    import plc_image_pkg::*;
#(
    parameter int WD_CYC = WD_CYC_DEF,
    parameter int MAX_LD = 15
) (
    input  logic                  CLK,
    input  logic                  CLR_N,
    input  logic                  START,
    input  logic [FIFO_DEPTH-1:0] IN_VEC,
    input  logic [4:0]            IN_CNT,
    image_scan_ctrl_if.master     bus,
    output logic                  BUSY,
    output logic [1:0]            PHASE,
    output logic                  SCAN_DONE,
    output logic [1:0]            ERR
);
    localparam int IW = $clog2(FIFO_DEPTH);

    logic [1:0]            r_state;
    logic [FIFO_DEPTH-1:0] r_vec;
    logic [4:0]            r_n;
    logic [IW-1:0]         r_idx;
    logic [1:0]            r_err;
    logic                  r_valid, r_data, r_done;

    logic w_start, w_wr, w_rd, w_last, w_wd_exp;

    assign w_start = START && (r_state == ST_IDLE);
    assign w_wr    = (r_state == ST_LOAD) && !bus.F_FULL;
    assign w_rd    = (r_state == ST_EXEC) && bus.CPU_REQ && !bus.F_EMPTY;
    assign w_last  = (5'(r_idx) + 5'd1) == r_n;

    // Strobes are decoded from the state so an async reset kills them at once.
    assign bus.F_EN      = w_wr || w_rd;
    assign bus.F_WR      = w_wr;
    assign bus.F_RD      = w_rd;
    assign bus.F_DIN     = w_wr && r_vec[r_idx];
    assign bus.F_CLR     = (r_state == ST_CLEAR);
    assign bus.CPU_VALID = r_valid;
    assign bus.CPU_DATA  = r_data;

    assign BUSY      = (r_state != ST_IDLE);
    assign PHASE     = r_state;
    assign SCAN_DONE = r_done;
    assign ERR       = r_err;

    image_wdt #(.WD_CYC(WD_CYC)) u_wdt (
        .CLK     (CLK),
        .CLR_N   (CLR_N),
        .CLR_CNT (w_start),
        .RUN     (BUSY),
        .EXPIRE  (w_wd_exp)
    );

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_n     <= '0;
            r_idx   <= '0;
            r_err   <= ERR_NONE;
            r_valid <= 1'b0;
            r_data  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_valid <= w_rd;
            // F_DOUT shows the FIFO head, so it is captured on the read edge.
            if (w_rd)
                r_data <= bus.F_DOUT;
            case (r_state)
                ST_IDLE: if (START) begin
                    r_vec   <= IN_VEC;
                    r_n     <= ld_count(IN_CNT, MAX_LD);
                    r_idx   <= '0;
                    r_err   <= ERR_NONE;
                    r_state <= ST_CLEAR;
                end
                ST_CLEAR: r_state <= (r_n != 5'd0) ? ST_LOAD : ST_EXEC;
                ST_LOAD: begin
                    if (bus.F_FULL) begin
                        r_err   <= ERR_OVF;
                        r_state <= ST_EXEC;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                        if (w_last)
                            r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (bus.CPU_REQ && bus.F_EMPTY)
                        r_err <= ERR_UNDR;
                    if (bus.CPU_DONE) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // Watchdog abort wins over any same-cycle completion.
            if (w_wd_exp) begin
                r_err   <= ERR_WDT;
                r_state <= ST_IDLE;
                r_done  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_image_scan_ctrl.sv
// Directed bench for image_scan_ctrl: behavioural bit FIFO, scoreboard queues
// filled by the stimulus and drained by a negedge monitor.
module tb_image_scan_ctrl;

    logic        CLK, CLR_N, START;
    logic [15:0] IN_VEC;
    logic [4:0]  IN_CNT;
    logic        BUSY, SCAN_DONE;
    logic [1:0]  PHASE, ERR;

    image_scan_ctrl_if bus ();

    image_scan_ctrl #(.WD_CYC(32), .MAX_LD(15)) dut (
        .CLK       (CLK),
        .CLR_N     (CLR_N),
        .START     (START),
        .IN_VEC    (IN_VEC),
        .IN_CNT    (IN_CNT),
        .bus       (bus),
        .BUSY      (BUSY),
        .PHASE     (PHASE),
        .SCAN_DONE (SCAN_DONE),
        .ERR       (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;

    bit exp_wr[$];
    bit exp_rd[$];
    bit exp_done[$];

    // Behavioural FIFO with first-word-fall-through output and adjustable full level.
    logic       fmem [16];
    logic [3:0] wp = '0;
    logic [3:0] rp = '0;
    int         fcnt = 0;
    int         full_lim = 16;

    always @(posedge CLK) begin
        if (bus.F_CLR) begin
            wp <= '0; rp <= '0; fcnt <= 0;
        end else begin
            if (bus.F_EN && bus.F_WR) begin
                fmem[wp] <= bus.F_DIN;
                wp <= wp + 4'd1;
            end
            if (bus.F_EN && bus.F_RD)
                rp <= rp + 4'd1;
            fcnt <= fcnt + ((bus.F_EN && bus.F_WR) ? 1 : 0) - ((bus.F_EN && bus.F_RD) ? 1 : 0);
        end
    end

    assign bus.F_DOUT  = fmem[rp];
    assign bus.F_EMPTY = (fcnt == 0);
    assign bus.F_FULL  = (fcnt >= full_lim);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_phase(input logic [1:0] ph, input int budget, input string nm);
        int n = 0;
        @(negedge CLK);
        while (PHASE !== ph && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk(nm, 32'(PHASE), 32'(ph));
    endtask

    always @(negedge CLK) begin : mon
        bit e;
        bit prev_rd;
        if (bus.F_WR) begin
            wr_cnt++;
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: got write din=%0d expected none", bus.F_DIN);
            end else begin
                e = exp_wr.pop_front();
                if (bus.F_DIN !== e) begin
                    bad++;
                    $display("FAIL wr_data: got %0d expected %0d", bus.F_DIN, e);
                end
            end
        end
        if ((bus.F_WR || bus.F_RD) && !bus.F_EN) begin
            total++; bad++;
            $display("FAIL f_en: got 0 expected 1 with strobe");
        end
        if (bus.F_RD && bus.F_WR) begin
            total++; bad++;
            $display("FAIL rd_wr_excl: got both 1 expected at most one");
        end
        if (bus.CPU_VALID) begin
            total++;
            if (exp_rd.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got valid data=%0d expected none", bus.CPU_DATA);
            end else begin
                e = exp_rd.pop_front();
                if (bus.CPU_DATA !== e) begin
                    bad++;
                    $display("FAIL rd_data: got %0d expected %0d", bus.CPU_DATA, e);
                end
            end
            total++;
            if (!prev_rd) begin
                bad++;
                $display("FAIL rd_latency: got valid without F_RD one cycle earlier expected F_RD=1");
            end
        end
        if (SCAN_DONE) begin
            total++;
            if (exp_done.size() == 0) begin
                bad++;
                $display("FAIL done_unexpected: got SCAN_DONE=1 expected 0");
            end else
                void'(exp_done.pop_front());
        end
        prev_rd = bus.F_RD;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish within limit");
        $fatal(1, "timeout");
    end

    bit s1b [8]  = '{1, 1, 0, 0, 0, 0, 1, 1};
    bit s3b [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

    initial begin
        CLR_N = 1'b0; START = 1'b0; IN_VEC = '0; IN_CNT = '0;
        bus.CPU_REQ = 1'b0; bus.CPU_DONE = 1'b0;
        #2;
        chk("rst_phase", 32'(PHASE), 0);
        chk("rst_busy",  32'(BUSY), 0);
        chk("rst_err",   32'(ERR), 0);
        chk("rst_valid", 32'(bus.CPU_VALID), 0);
        chk("rst_done",  32'(SCAN_DONE), 0);
        chk("rst_fclr",  32'(bus.F_CLR), 0);
        repeat (2) cyc();
        CLR_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_fclr", 32'(bus.F_CLR), 0);

        // 1: 8-bit load and readback
        IN_VEC = 16'hA5C3; IN_CNT = 5'd8; START = 1'b1;
        foreach (s1b[i]) exp_wr.push_back(s1b[i]);
        wr_cnt = 0;
        cyc(); START = 1'b0;
        @(negedge CLK);
        chk("s1_clear_phase", 32'(PHASE), 1);
        chk("s1_fclr", 32'(bus.F_CLR), 1);
        chk("s1_busy", 32'(BUSY), 1);
        cyc(); @(negedge CLK);
        chk("s1_load_phase", 32'(PHASE), 2);
        chk("s1_fclr_once", 32'(bus.F_CLR), 0);
        repeat (8) cyc();
        @(negedge CLK);
        chk("s1_exec_phase", 32'(PHASE), 3);
        chk("s1_wr_cnt", 32'(wr_cnt), 8);
        foreach (s1b[i]) exp_rd.push_back(s1b[i]);
        bus.CPU_REQ = 1'b1;
        repeat (8) cyc();
        bus.CPU_REQ = 1'b0; bus.CPU_DONE = 1'b1; exp_done.push_back(1'b1);
        cyc(); bus.CPU_DONE = 1'b0;
        @(negedge CLK);
        chk("s1_idle", 32'(PHASE), 0);
        chk("s1_scan_done", 32'(SCAN_DONE), 1);
        chk("s1_err", 32'(ERR), 0);
        cyc(); @(negedge CLK);
        chk("s1_done_pulse", 32'(SCAN_DONE), 0);

        // 2: zero-length load, underrun
        IN_VEC = 16'hFFFF; IN_CNT = 5'd0; START = 1'b1;
        cyc(); START = 1'b0;
        @(negedge CLK);
        chk("s2_clear", 32'(PHASE), 1);
        cyc(); @(negedge CLK);
        chk("s2_exec", 32'(PHASE), 3);
        bus.CPU_REQ = 1'b1;
        #1;
        chk("s2_no_rd", 32'(bus.F_RD), 0);
        cyc(); bus.CPU_REQ = 1'b0;
        @(negedge CLK);
        chk("s2_no_valid", 32'(bus.CPU_VALID), 0);
        chk("s2_err", 32'(ERR), 2);
        bus.CPU_DONE = 1'b1; exp_done.push_back(1'b1);
        cyc(); bus.CPU_DONE = 1'b0;
        @(negedge CLK);
        chk("s2_idle", 32'(PHASE), 0);
        chk("s2_err_sticky", 32'(ERR), 2);

        // 3: clamped count, FIFO fills after 10 writes
        full_lim = 10;
        IN_VEC = 16'hF0F0; IN_CNT = 5'd20; START = 1'b1;
        foreach (s3b[i]) exp_wr.push_back(s3b[i]);
        wr_cnt = 0;
        cyc(); START = 1'b0;
        @(negedge CLK);
        chk("s3_err_cleared", 32'(ERR), 0);
        wait_phase(2'd3, 40, "s3_reach_exec");
        chk("s3_wr_cnt", 32'(wr_cnt), 10);
        chk("s3_err_ovf", 32'(ERR), 1);
        chk("s3_phase", 32'(PHASE), 3);
        bus.CPU_DONE = 1'b1; exp_done.push_back(1'b1);
        cyc(); bus.CPU_DONE = 1'b0;
        @(negedge CLK);
        chk("s3_idle", 32'(PHASE), 0);
        full_lim = 16;

        // 4: watchdog abort at cycle 32
        IN_VEC = 16'h0002; IN_CNT = 5'd2; START = 1'b1;
        exp_wr.push_back(1'b0); exp_wr.push_back(1'b1);
        cyc(); START = 1'b0;
        repeat (31) cyc();
        @(negedge CLK);
        chk("s4_still_exec", 32'(PHASE), 3);
        cyc(); @(negedge CLK);
        chk("s4_idle", 32'(PHASE), 0);
        chk("s4_busy", 32'(BUSY), 0);
        chk("s4_err_wdt", 32'(ERR), 3);
        chk("s4_no_done", 32'(SCAN_DONE), 0);

        // 5: reset while loading bit 4
        IN_VEC = 16'hFFFF; IN_CNT = 5'd10; START = 1'b1;
        repeat (4) exp_wr.push_back(1'b1);
        wr_cnt = 0;
        cyc(); START = 1'b0;
        cyc();
        repeat (4) cyc();
        CLR_N = 1'b0;
        #1;
        chk("s5_phase", 32'(PHASE), 0);
        chk("s5_busy", 32'(BUSY), 0);
        chk("s5_fwr", 32'(bus.F_WR), 0);
        chk("s5_fclr", 32'(bus.F_CLR), 0);
        chk("s5_cpu_data", 32'(bus.CPU_DATA), 0);
        chk("s5_valid", 32'(bus.CPU_VALID), 0);
        chk("s5_done", 32'(SCAN_DONE), 0);
        repeat (2) cyc();
        chk("s5_wr_cnt", 32'(wr_cnt), 4);
        CLR_N = 1'b1;
        @(negedge CLK);
        chk("s5_post_fclr", 32'(bus.F_CLR), 0);
        chk("s5_post_phase", 32'(PHASE), 0);

        // 6: START ignored in EXEC; REQ and DONE together
        IN_VEC = 16'h0005; IN_CNT = 5'd3; START = 1'b1;
        exp_wr.push_back(1'b1); exp_wr.push_back(1'b0); exp_wr.push_back(1'b1);
        cyc(); START = 1'b0;
        cyc();
        repeat (3) cyc();
        @(negedge CLK);
        chk("s6_exec", 32'(PHASE), 3);
        IN_VEC = 16'hFFFF; IN_CNT = 5'd1; START = 1'b1;
        cyc(); START = 1'b0;
        @(negedge CLK);
        chk("s6_start_ignored", 32'(PHASE), 3);
        chk("s6_no_clear", 32'(bus.F_CLR), 0);
        exp_rd.push_back(1'b1); exp_done.push_back(1'b1);
        bus.CPU_REQ = 1'b1; bus.CPU_DONE = 1'b1;
        cyc(); bus.CPU_REQ = 1'b0; bus.CPU_DONE = 1'b0;
        @(negedge CLK);
        chk("s6_idle", 32'(PHASE), 0);
        chk("s6_valid", 32'(bus.CPU_VALID), 1);
        chk("s6_data", 32'(bus.CPU_DATA), 1);
        chk("s6_scan_done", 32'(SCAN_DONE), 1);
        cyc(); @(negedge CLK);
        chk("s6_one_valid", 32'(bus.CPU_VALID), 0);

        cyc();
        chk("wr_queue_drained", 32'(exp_wr.size()), 0);
        chk("rd_queue_drained", 32'(exp_rd.size()), 0);
        chk("done_queue_drained", 32'(exp_done.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/image_scan_ctrl.md
IMAGE_SCAN_CTRL -- requirements
Module: image_scan_ctrl

Interface
REQ-001 Parameters SHALL be:
- WD_CYC, default 1024: scan watchdog limit in clock cycles.
- MAX_LD, default 15: maximum bits loaded per scan.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK  in  1  clock, rising edge.
- CLR_N  in  1  reset, asynchronous, active-low.
- START  in  1  pulse; begins a scan cycle.
- IN_VEC  in  16  parallel input image.
- IN_CNT  in  5  number of bits to load.
- CPU_REQ  in  1  CPU requests the next image bit.
- CPU_DONE  in  1  pulse; CPU program pass finished.
- CPU_DATA  out  1  image bit.
- CPU_VALID  out  1  CPU_DATA valid.
- F_EN, F_RD, F_WR, F_DIN, F_CLR  out  1 each  FIFO controls.
- F_DOUT, F_EMPTY, F_FULL  in  1 each  FIFO status.
- BUSY  out  1  scan in progress.
- PHASE  out  2  current state encoding.
- SCAN_DONE  out  1  completion pulse.
- ERR  out  2  sticky error code.
REQ-003 The block SHALL have one clock, CLK; reset CLR_N is asynchronous and active-low.

Function
REQ-004 The FSM SHALL have states IDLE=0, CLEAR=1, LOAD=2, EXEC=3.
REQ-005 In IDLE, START=1 SHALL capture IN_VEC and N=min(IN_CNT,MAX_LD) into registers and go to CLEAR; START in any other state SHALL be ignored.
REQ-006 CLEAR SHALL last exactly one cycle with F_CLR=1, then go to LOAD if N>0, otherwise to EXEC.
REQ-007 In LOAD, each cycle SHALL drive F_EN=1, F_WR=1, F_DIN=IN_VEC[i] for i=0,1,...,N-1, so that N bits are written in N consecutive cycles.
REQ-008 LOAD SHALL exit to EXEC after bit N-1 is written.
REQ-009 If F_FULL=1 during LOAD, the block SHALL stop writing, set ERR=2'b01 (overflow), and go to EXEC.
REQ-010 F_RD and F_WR SHALL never both be 1 in the same cycle.
REQ-011 In EXEC, CPU_REQ=1 with F_EMPTY=0 SHALL drive F_EN=1 and F_RD=1 combinationally in that cycle.
REQ-012 CPU_VALID SHALL be 1 in the following cycle with CPU_DATA=F_DOUT; latency is 1 cycle and back-to-back requests give one bit per cycle.
REQ-013 In EXEC, CPU_REQ=1 with F_EMPTY=1 SHALL leave F_RD=0 and CPU_VALID=0 next cycle, and SHALL set ERR=2'b10 (underrun).
REQ-014 CPU_DONE=1 in EXEC SHALL return the FSM to IDLE and pulse SCAN_DONE for one cycle.
REQ-015 CPU_DONE and CPU_REQ asserted in the same cycle SHALL let the read complete (CPU_VALID next cycle) and then go to IDLE.
REQ-016 A watchdog counter SHALL clear on START acceptance and increment while BUSY.
REQ-017 When the watchdog count reaches WD_CYC-1, the block SHALL set ERR=2'b11, go to IDLE, and not pulse SCAN_DONE.
REQ-018 ERR SHALL be sticky and SHALL clear only on START acceptance or reset; a later error overwrites an earlier one.
REQ-019 BUSY SHALL be 1 in every state except IDLE, and PHASE SHALL equal the state encoding.
REQ-020 F_EN, F_RD and F_WR SHALL be 0 in IDLE.

Reset
REQ-021 While CLR_N=0, the block SHALL immediately be in IDLE with:
- CPU_VALID, CPU_DATA, SCAN_DONE, BUSY, F_CLR = 0.
- ERR = 0.
- Watchdog count = 0, bit index = 0.
REQ-022 CLR_N asserted mid-scan SHALL abort the scan, with no SCAN_DONE and no further FIFO writes.
REQ-023 The first cycle after CLR_N deasserts SHALL drive F_CLR=0.

Structure
REQ-024 State encodings, ERR codes, the FIFO depth (16) and the WD_CYC default SHALL reside in shared package plc_image_pkg.
REQ-025 The watchdog SHALL be a sub-module, image_wdt, with ports CLK, CLR_N, CLR_CNT, RUN and EXPIRE.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- IN_VEC=16'hA5C3, IN_CNT=8, START -> CLEAR 1 cycle; F_WR for 8 cycles with bits 1,1,0,0,0,0,1,1; 8 CPU_REQ give CPU_DATA=1,1,0,0,0,0,1,1 at 1-cycle latency; CPU_DONE -> SCAN_DONE pulse, ERR=0.
- IN_CNT=0 -> CLEAR then EXEC directly; CPU_REQ -> CPU_VALID=0, ERR=2'b10.
- IN_CNT=20, F_FULL forced to 1 after 10 writes -> exactly 10 F_WR pulses, ERR=2'b01, PHASE=3.
- WD_CYC=32, no CPU_DONE -> IDLE on cycle 32 after START, ERR=2'b11, no SCAN_DONE.
- CLR_N low during LOAD at bit 4 -> outputs at reset values immediately, no further F_WR.
- CPU_DONE and CPU_REQ in the same cycle -> one CPU_VALID, then IDLE; START in EXEC is ignored.
